// File: rtl/rx_lane_scheduler.sv
// Round-robin sharing of one serial frame receiver among N_LANES sources.
// Grants a lane, steers its bit stream to the receiver and returns the result over valid/ready.
module rx_lane_scheduler #(
    parameter int N_LANES    = 4,
    parameter int LANE_W     = $clog2(N_LANES),
    parameter int TIMEOUT    = 4,
    parameter int RESET_HOLD = 10
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [N_LANES-1:0] lane_req,
    output logic [N_LANES-1:0] lane_gnt,
    input  logic [N_LANES-1:0] lane_rxd,
    output logic               rx_start,
    output logic               rx_rxd,
    input  logic               rx_idle,
    input  logic [7:0]         rx_data,
    input  logic               rx_error,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic [LANE_W-1:0]  out_lane,
    output logic               out_error,
    output logic               out_timeout,
    output logic               busy
);

    // state  | meaning
    // HOLD   | post-reset drain of a receiver frame that may still be in flight
    // IDLE   | waiting for any lane request
    // GRANT  | one-cycle lane grant and receiver start pulse
    // RECV   | nine bit times, selected lane steered onto rx_rxd
    // WAIT   | waiting for rx_idle, bounded by TIMEOUT
    // DONE   | result presented, waiting for out_ready
    typedef enum logic [2:0] {
        S_HOLD,
        S_IDLE,
        S_GRANT,
        S_RECV,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int MAX_A   = (RESET_HOLD > TIMEOUT) ? RESET_HOLD : TIMEOUT;
    localparam int TMR_MAX = (MAX_A > 9) ? MAX_A : 9;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t              state;
    logic [TMR_W-1:0]    tmr;
    logic [LANE_W-1:0]   sel;
    logic [LANE_W-1:0]   rr_ptr;
    logic [LANE_W-1:0]   arb_sel;
    logic                arb_hit;
    logic                grant_now;
    int                  scan;

    // rr_ptr is the first lane searched, i.e. one past the last granted lane
    always_comb begin
        arb_hit = 1'b0;
        arb_sel = '0;
        scan    = 0;
        for (int i = 0; i < N_LANES; i++) begin
            scan = int'(rr_ptr) + i;
            if (scan >= N_LANES) scan = scan - N_LANES;
            if (!arb_hit && lane_req[scan[LANE_W-1:0]]) begin
                arb_hit = 1'b1;
                arb_sel = scan[LANE_W-1:0];
            end
        end
    end

    assign grant_now = arb_hit && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign rx_rxd    = (state == S_RECV) ? lane_rxd[sel] : 1'b0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= S_HOLD;
            tmr         <= TMR_W'(RESET_HOLD - 1);
            sel         <= '0;
            rr_ptr      <= '0;
            lane_gnt    <= '0;
            rx_start    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_lane    <= '0;
            out_error   <= 1'b0;
            out_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            lane_gnt <= '0;
            rx_start <= 1'b0;
            case (state)
                S_HOLD: begin
                    busy <= 1'b1;
                    if (tmr == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_IDLE: begin
                    busy <= 1'b0;
                end
                S_GRANT: begin
                    state <= S_RECV;
                    tmr   <= TMR_W'(8);
                end
                S_RECV: begin
                    if (tmr == '0) begin
                        state <= S_WAIT;
                        tmr   <= TMR_W'(TIMEOUT - 1);
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_WAIT: begin
                    if (rx_idle) begin
                        out_valid   <= 1'b1;
                        out_data    <= rx_data;
                        out_error   <= rx_error;
                        out_timeout <= 1'b0;
                        out_lane    <= sel;
                        state       <= S_DONE;
                    end else if (tmr == '0) begin
                        out_valid   <= 1'b1;
                        out_data    <= '0;
                        out_error   <= 1'b0;
                        out_timeout <= 1'b1;
                        out_lane    <= sel;
                        state       <= S_DONE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_HOLD;
                    tmr   <= TMR_W'(RESET_HOLD - 1);
                end
            endcase

            // DONE with a handshake re-arbitrates in the same edge, skipping IDLE
            if (grant_now) begin
                state    <= S_GRANT;
                busy     <= 1'b1;
                sel      <= arb_sel;
                lane_gnt <= N_LANES'(1) << arb_sel;
                rx_start <= 1'b1;
                if (arb_sel == LANE_W'(N_LANES - 1)) rr_ptr <= '0;
                else                                 rr_ptr <= arb_sel + LANE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rx_lane_scheduler.sv
// Directed bench for rx_lane_scheduler with lane sources, a receiver model and a result scoreboard.
module tb_rx_lane_scheduler;

    localparam int N          = 4;
    localparam int LW         = 2;
    localparam int TIMEOUT    = 4;
    localparam int RESET_HOLD = 10;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [N-1:0]  lane_req;
    logic [N-1:0]  lane_gnt;
    logic [N-1:0]  lane_rxd = '0;
    logic          rx_start;
    logic          rx_rxd;
    logic          rx_idle  = 1'b1;
    logic [7:0]    rx_data  = 8'h00;
    logic          rx_error = 1'b0;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [LW-1:0] out_lane;
    logic          out_error;
    logic          out_timeout;
    logic          busy;

    always #5 Clk = ~Clk;

    rx_lane_scheduler #(
        .N_LANES(N), .LANE_W(LW), .TIMEOUT(TIMEOUT), .RESET_HOLD(RESET_HOLD)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .lane_req(lane_req), .lane_gnt(lane_gnt), .lane_rxd(lane_rxd),
        .rx_start(rx_start), .rx_rxd(rx_rxd), .rx_idle(rx_idle),
        .rx_data(rx_data), .rx_error(rx_error),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_error(out_error), .out_timeout(out_timeout),
        .busy(busy)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        int         lane;
        logic [7:0] data;
        logic       err;
        logic       tmo;
    } res_t;

    res_t res_q[$];
    int   gnt_q[$];

    logic [8:0] frame [N];
    logic [3:0] lcnt  [N];
    logic [3:0] rcnt     = 4'd0;
    logic [8:0] rsh      = 9'd0;
    logic       hold_low = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // Lane sources: bit k of the frame is presented in the k-th cycle after the grant
    always @(posedge Clk) begin
        for (int i = 0; i < N; i++) begin
            if (lane_gnt[i]) begin
                lane_rxd[i] <= frame[i][0];
                lcnt[i]     <= 4'd1;
            end else if (lcnt[i] != 4'd0) begin
                if (lcnt[i] < 4'd9) begin
                    lane_rxd[i] <= frame[i][lcnt[i]];
                    lcnt[i]     <= lcnt[i] + 4'd1;
                end else begin
                    lane_rxd[i] <= 1'b0;
                    lcnt[i]     <= 4'd0;
                end
            end
        end
    end

    // Receiver: no reset, samples edges G+2..G+10, idle back in G+11
    always @(posedge Clk) begin
        if (rx_start) begin
            rcnt    <= 4'd1;
            rx_idle <= 1'b0;
        end else if (rcnt >= 4'd1 && rcnt <= 4'd9) begin
            rsh  <= {rx_rxd, rsh[8:1]};
            rcnt <= rcnt + 4'd1;
        end else if (rcnt == 4'd10) begin
            rx_data  <= rsh[7:0];
            rx_error <= ^rsh;
            rx_idle  <= !hold_low;
            rcnt     <= 4'd0;
        end
    end

    // Monitor: grant order, result latency/content, stability under backpressure
    int          gnt_cyc    = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b1;
    logic [11:0] snap       = '0;

    always @(negedge Clk) begin
        int   exp_l;
        res_t er;
        if (!Rst) begin
            if (lane_gnt != '0) begin
                check("gnt_expected", 32'(gnt_q.size() != 0), 1);
                if (gnt_q.size() != 0) begin
                    exp_l = gnt_q.pop_front();
                    check("lane_gnt", 32'(lane_gnt), 32'(1) << exp_l);
                end
                check("rx_start_with_gnt", 32'(rx_start), 1);
                gnt_cyc = cyc;
            end
            if (out_valid && !prev_valid) begin
                check("result_expected", 32'(res_q.size() != 0), 1);
                if (res_q.size() != 0) begin
                    er = res_q.pop_front();
                    check("result_latency", cyc - gnt_cyc, er.tmo ? 10 + TIMEOUT : 12);
                    check("out_data", 32'(out_data), 32'(er.data));
                    check("out_lane", 32'(out_lane), er.lane);
                    check("out_error", 32'(out_error), 32'(er.err));
                    check("out_timeout", 32'(out_timeout), 32'(er.tmo));
                end
            end
            if (out_valid && prev_valid && !prev_ready)
                check("hold_stable", 32'({out_data, out_lane, out_error, out_timeout}), 32'(snap));
        end
        prev_valid = out_valid && !Rst;
        prev_ready = out_ready;
        snap       = {out_data, out_lane, out_error, out_timeout};
    end

    task automatic wait_gnt(output int c);
        bit found = 0;
        c = -1;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge Clk);
            if (lane_gnt != '0) begin
                found = 1;
                c     = cyc;
            end
        end
        check("gnt_seen", 32'(found), 1);
    endtask

    task automatic wait_valid();
        bit found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge Clk);
            if (out_valid) found = 1;
        end
        check("valid_seen", 32'(found), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lane_gnt"}, 32'(lane_gnt), 0);
        check({tag, "_rx_start"}, 32'(rx_start), 0);
        check({tag, "_rx_rxd"}, 32'(rx_rxd), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"}, 32'(out_data), 0);
        check({tag, "_out_lane"}, 32'(out_lane), 0);
        check({tag, "_out_error"}, 32'(out_error), 0);
        check({tag, "_out_timeout"}, 32'(out_timeout), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    function automatic res_t mk_res(input int lane, input logic [8:0] f, input logic tmo);
        res_t r;
        r.lane = lane;
        r.data = tmo ? 8'h00 : f[7:0];
        r.err  = tmo ? 1'b0 : ^f;
        r.tmo  = tmo;
        return r;
    endfunction

    // One isolated frame with out_ready high and no other requests
    task automatic run_one(input int lane, input logic [8:0] f, input logic tmo);
        int g;
        frame[lane] = f;
        gnt_q.push_back(lane);
        res_q.push_back(mk_res(lane, f, tmo));
        lane_req[lane] = 1'b1;
        wait_gnt(g);
        lane_req[lane] = 1'b0;
        @(negedge Clk);
        check("busy_in_frame", 32'(busy), 1);
        check("rx_start_pulse", 32'(rx_start), 0);
        wait_valid();
        @(negedge Clk);
        check("valid_cleared", 32'(out_valid), 0);
        check("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, gp, h, rel;
        Rst       = 1'b1;
        lane_req  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) frame[i] = 9'd0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("reset");

        // Release reset; first frame also checks the post-reset hold
        Rst = 1'b0;
        rel = cyc;
        frame[1] = {1'b0, 8'hA5};
        gnt_q.push_back(1);
        res_q.push_back(mk_res(1, frame[1], 1'b0));
        lane_req[1] = 1'b1;
        wait_gnt(g);
        lane_req[1] = 1'b0;
        check("hold_before_first_grant", 32'((g - rel) > RESET_HOLD), 1);
        wait_valid();
        @(negedge Clk);
        check("valid_cleared", 32'(out_valid), 0);

        // Parity error, then receiver that never returns idle
        run_one(2, {1'b0, 8'h01}, 1'b0);
        hold_low = 1'b1;
        run_one(3, {1'b0, 8'h3C}, 1'b1);
        hold_low = 1'b0;

        // Round-robin with all lanes requesting
        frame[0] = {1'b0, 8'h12};
        frame[1] = {1'b1, 8'h34};
        frame[2] = {1'b0, 8'h56};
        frame[3] = {1'b1, 8'h7F};
        for (int k = 0; k < 5; k++) begin
            gnt_q.push_back(k % N);
            res_q.push_back(mk_res(k % N, frame[k % N], 1'b0));
        end
        lane_req = '1;
        gp = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g);
            if (k > 0) check("rr_spacing", g - gp, 13);
            gp = g;
        end
        lane_req = '0;
        wait_valid();
        @(negedge Clk);

        // Backpressure: result held, no grant until the handshake edge
        @(posedge Clk); #2;
        out_ready = 1'b0;
        frame[1] = {1'b1, 8'h5A};
        frame[2] = {1'b1, 8'h80};
        gnt_q.push_back(1);
        res_q.push_back(mk_res(1, frame[1], 1'b0));
        gnt_q.push_back(2);
        res_q.push_back(mk_res(2, frame[2], 1'b0));
        lane_req = 4'b0110;
        wait_gnt(g);
        lane_req[1] = 1'b0;
        wait_valid();
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            check("bp_no_gnt", 32'(lane_gnt), 0);
        end
        @(posedge Clk); #2;
        out_ready = 1'b1;
        h = cyc;
        wait_gnt(g);
        lane_req[2] = 1'b0;
        check("bp_gnt_on_handshake", g, h + 1);
        wait_valid();
        @(negedge Clk);

        // Reset during RECV counter 4, then arbitration from lane 0
        frame[1] = {1'b1, 8'hC3};
        gnt_q.push_back(1);
        lane_req[1] = 1'b1;
        wait_gnt(g);
        lane_req[1] = 1'b0;
        repeat (5) @(posedge Clk);
        #2;
        Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("midrecv");
        Rst = 1'b0;
        rel = cyc;
        frame[0] = {1'b0, 8'h99};
        frame[3] = {1'b0, 8'h0E};
        gnt_q.push_back(0);
        res_q.push_back(mk_res(0, frame[0], 1'b0));
        gnt_q.push_back(3);
        res_q.push_back(mk_res(3, frame[3], 1'b0));
        lane_req = 4'b1001;
        wait_gnt(g);
        lane_req[0] = 1'b0;
        check("hold_after_midrecv", 32'((g - rel) > RESET_HOLD), 1);
        wait_valid();
        wait_gnt(g);
        lane_req[3] = 1'b0;
        wait_valid();
        @(negedge Clk);

        check("gnt_q_drained", gnt_q.size(), 0);
        check("res_q_drained", res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rx_lane_scheduler.md
# rx_lane_scheduler

Round-robin scheduler that shares one serial frame receiver among N_LANES serial sources. It arbitrates lane requests and issues the receiver start pulse. It steers the granted lane's bit stream onto the receiver input, waits for the receiver to return idle, and hands the received byte, parity error, and lane ID to a downstream consumer over a valid/ready interface.

## Interface
- N_LANES, 4: number of serial sources; must be at least 2.
- LANE_W, $clog2(N_LANES): width of the lane ID.
- TIMEOUT, 4: maximum WAIT cycles for rx_idle before the frame is abandoned.
- RESET_HOLD, 10: cycles after reset release before the first grant is allowed.
- Clk  in  1  clock; all logic on posedge.
- Rst  in  1  synchronous, active-high reset.
- lane_req  in  N_LANES  lane i has a frame ready; held until granted.
- lane_gnt  out  N_LANES  one-hot, one-cycle grant pulse.
- lane_rxd  in  N_LANES  serial bit from each lane.
- rx_start  out  1  frame start pulse to the receiver.
- rx_rxd  out  1  serial bit to the receiver.
- rx_idle  in  1  receiver idle flag.
- rx_data  in  8  received byte.
- rx_error  in  1  receiver parity error.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  8  received byte.
- out_lane  out  LANE_W  source lane of the result.
- out_error  out  1  parity error flag.
- out_timeout  out  1  receiver never returned idle.
- busy  out  1  high in every state except IDLE.

## Operation
- **Receiver contract.** rx_start high in cycle G. The receiver samples rx_rxd at edges G+2 through G+10. This carries data bits 0–7, LSB first, then the parity bit. Parity is even over the 9 bits; rx_error=1 on mismatch. rx_idle falls by cycle G+1 and rises in cycle G+11. rx_idle is meaningless before the first frame and is ignored outside WAIT.
- **States:** HOLD, IDLE, GRANT, RECV, WAIT, DONE.
- **HOLD.** Entered on reset. Stays for RESET_HOLD cycles so that any frame in flight in the receiver, which has no reset, drains. Then goes to IDLE.
- **IDLE.** If any lane_req is high, pick a lane round-robin, starting from the lane after the last granted lane. The first pick after reset searches from lane 0. Latch the pick as sel and go to GRANT.
- **GRANT (1 cycle).** lane_gnt[sel]=1 and rx_start=1. Go to RECV.
- **RECV (9 cycles, counter 0..8).** rx_rxd = lane_rxd[sel], combinational mux. The lane must drive bit k in the k-th RECV cycle. Go to WAIT.
- **WAIT.** If rx_idle=1, capture rx_data, rx_error and sel into the out_* registers, set out_valid, and go to DONE. After TIMEOUT cycles without rx_idle, set out_valid with out_timeout=1, out_data=0, out_error=0, and go to DONE.
- **DONE.** Hold out_* stable while out_valid and !out_ready.
  - On the handshake edge, clear out_valid.
  - In the same edge, if any lane_req is high, arbitrate and go directly to GRANT; otherwise go to IDLE.
- rx_rxd=0 in every state except RECV. lane_req of the granted lane is ignored during GRANT.
- A lane with no request is skipped. A lane that holds its request can wait at most N_LANES-1 frames.

## Timing
- **Reset.** Every output is 0: lane_gnt, rx_start, rx_rxd, out_*, busy. The round-robin pointer points at lane 0 and the state is HOLD.
- **Reset mid-frame.** The frame is abandoned with no output. HOLD guarantees the receiver is idle before the next start.
- **Request to grant.** A request sampled at edge E in IDLE gives a grant in cycle E.
- **Grant to result.** Grant in cycle G gives out_valid first high in cycle G+12.
- **Throughput.** With out_ready tied to 1 and requests pending, grants are 13 cycles apart.
- **Backpressure.** With out_ready low, no new grant is issued. out_* stay stable.
- **Simultaneous requests.** Exactly one grant per arbitration. The pointer advances only on a grant.

## Test plan
- **Single frame, good parity.** Reset, then lane 1 requests and sends 0xA5 with parity 0. Required: lane_gnt=4'b0010, and out_valid in cycle G+12 with out_data=0xA5, out_lane=1, out_error=0, out_timeout=0.
- **Parity error.** Lane 2 sends 0x01 with parity 0. Required: out_data=0x01, out_error=1, out_lane=2.
- **Round-robin.** All four lanes request continuously. Required: grants in order 0,1,2,3,0, each 13 cycles apart with out_ready=1.
- **Backpressure.** out_ready=0 for 20 cycles after the first result. Required: out_* stable and no lane_gnt until the handshake; the next grant comes on the handshake edge.
- **Timeout.** The receiver model holds rx_idle=0. Required: out_valid in cycle G+10+TIMEOUT with out_timeout=1 and out_data=0.
- **Reset mid-RECV.** Assert Rst in RECV counter 4. Required: all outputs 0, no grant for RESET_HOLD cycles after release, then normal arbitration starting from lane 0.
